// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled as one port.
// The slave modport is the cache; the master modport is the datapath plus memory controller.
interface icache_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped, read-only, one-word-per-frame instruction cache.
// Hits answer combinationally; a miss runs one blocking word fill from memory.
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    icache_responder_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {IDLE, MISS} state_t;

    state_t            r_state, w_state_next;
    logic [31:0]       r_miss_addr, w_miss_addr_next;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [31:0]       r_data [SETS];

    logic [IDX_W-1:0]  w_idx, w_fill_idx;
    logic [TAG_W-1:0]  w_tag, w_fill_tag;
    logic              w_hit, w_fill;

    assign w_idx      = bus.imemaddr[IDX_W+1:2];
    assign w_tag      = bus.imemaddr[31:IDX_W+2];
    assign w_fill_idx = r_miss_addr[IDX_W+1:2];
    assign w_fill_tag = r_miss_addr[31:IDX_W+2];
    assign w_hit      = bus.imemREN && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Only valid bits need reset; tag/data are qualified by valid.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= bus.iload;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_miss_addr <= w_miss_addr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_miss_addr_next = r_miss_addr;
        w_fill           = 1'b0;
        bus.ihit         = 1'b0;
        bus.imemload     = '0;
        bus.iREN         = 1'b0;
        bus.iaddr        = '0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    bus.ihit     = 1'b1;
                    bus.imemload = r_data[w_idx];
                end else if (bus.imemREN) begin
                    w_miss_addr_next = {bus.imemaddr[31:2], 2'b00};
                    w_state_next     = MISS;
                end
            end
            MISS: begin
                // The fill runs to completion regardless of what the fetch side does meanwhile.
                bus.iREN  = 1'b1;
                bus.iaddr = r_miss_addr;
                if (!bus.iwait) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_responder.sv
// Randomized and directed bench for icache_responder against a line-address reference model.
module tb_icache_responder;
    localparam int SETS = 16;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    icache_responder_if bus ();

    icache_responder #(.SETS(SETS)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: each set remembers the full word address it holds.
    bit          m_valid [SETS];
    logic [31:0] m_line  [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_busy;
    logic [31:0] m_miss;
    int          m_wait;
    logic [31:0] mem_over [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return !m_busy && m_valid[set_of(a)] && (m_line[set_of(a)] == wa);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0;
        m_wait = 0;
    endtask

    // One clock cycle: drive at +1 after the edge, check at negedge, update model at posedge.
    task automatic step(input bit req, input logic [31:0] addr, input int wait_if_miss,
                        output bit dut_hit);
        bit          exp_hit;
        logic [31:0] wa;
        int          s;
        bus.imemREN  = req;
        bus.imemaddr = addr;
        if (m_busy) begin
            bus.iwait = (m_wait > 0);
            bus.iload = bus.iwait ? $urandom : mem_word(m_miss);
        end else begin
            bus.iwait = 1'($urandom_range(0, 1));
            bus.iload = $urandom;
        end
        @(negedge CLK);
        wa      = {addr[31:2], 2'b00};
        s       = set_of(addr);
        exp_hit = req && model_hit(addr);
        check("ihit",     {31'b0, bus.ihit}, {31'b0, exp_hit});
        check("imemload", bus.imemload,      exp_hit ? m_data[s] : 32'h0);
        check("iREN",     {31'b0, bus.iREN}, {31'b0, m_busy});
        check("iaddr",    bus.iaddr,         m_busy ? m_miss : 32'h0);
        dut_hit = bus.ihit;
        if (exp_hit) $display("hit  addr=%h data=%h", addr, m_data[s]);
        @(posedge CLK);
        if (m_busy) begin
            if (m_wait == 0) begin
                m_valid[set_of(m_miss)] = 1'b1;
                m_line[set_of(m_miss)]  = m_miss;
                m_data[set_of(m_miss)]  = mem_word(m_miss);
                m_busy = 1'b0;
                $display("fill addr=%h data=%h", m_miss, mem_word(m_miss));
            end else begin
                m_wait--;
            end
        end else if (req && !exp_hit) begin
            m_busy = 1'b1;
            m_miss = wa;
            m_wait = wait_if_miss;
        end
        #1;
    endtask

    // Request until the DUT hits; latency is the number of cycles before the hit cycle.
    task automatic fetch(input logic [31:0] a, input int w);
        int exp_lat;
        int n;
        bit h;
        exp_lat = model_hit(a) ? 0 : w + 2;
        n = 0;
        h = 1'b0;
        step(1'b1, a, w, h);
        while (!h && n < 64) begin
            n++;
            step(1'b1, a, w, h);
        end
        check("latency", n, exp_lat);
    endtask

    task automatic drain();
        bit h;
        for (int i = 0; i < 64 && m_busy; i++) step(1'b0, 32'h0, 0, h);
        check("drain", {31'b0, m_busy}, 32'h0);
    endtask

    initial begin
        bit h;
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h40;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;
        model_clear();

        // Reset state with a request already presented.
        #2;
        check("rst_ihit",     {31'b0, bus.ihit}, 32'h0);
        check("rst_imemload", bus.imemload,      32'h0);
        check("rst_iREN",     {31'b0, bus.iREN}, 32'h0);
        check("rst_iaddr",    bus.iaddr,         32'h0);
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;

        // Cold miss, zero wait, then hits ignoring byte offset.
        mem_over[32'h40] = 32'hDEAD_BEEF;
        fetch(32'h40, 0);
        fetch(32'h40, 0);
        fetch(32'h42, 0);
        check("deadbeef", m_data[set_of(32'h40)], 32'hDEAD_BEEF);

        // Conflict eviction in set 1.
        fetch(32'h04, 1);
        fetch(32'h44, 0);
        fetch(32'h04, 2);
        fetch(32'h44, 0);

        // Long memory wait.
        fetch(32'h100, 5);

        // Request changes and drops during the miss.
        step(1'b1, 32'h200, 3, h);
        step(1'b0, 32'h300, 0, h);
        step(1'b0, 32'h300, 0, h);
        drain();
        fetch(32'h200, 0);
        fetch(32'h300, 1);

        // Reset in the middle of a miss.
        step(1'b1, 32'h80, 4, h);
        step(1'b1, 32'h80, 4, h);
        nRST = 1'b0;
        #1;
        check("rstmid_iREN",  {31'b0, bus.iREN}, 32'h0);
        check("rstmid_iaddr", bus.iaddr,         32'h0);
        model_clear();
        @(posedge CLK); @(posedge CLK); #1;
        nRST = 1'b1;
        fetch(32'h80, 1);
        fetch(32'h40, 0);

        // Random traffic over a small address pool to mix hits, misses and conflicts.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, SETS - 1)), 2'($urandom_range(0, 3))};
            step(($urandom_range(0, 9) < 8), a, $urandom_range(0, 3), h);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
